// File: rtl/modulo_buffer_contador.sv
// Preset buffer stage: a circular FIFO of preset values feeding an output
// register that the downstream counter control FSM consumes with Load_C.
// The output register is refilled from the FIFO head. A write into an empty
// stage always passes through storage first.
module modulo_buffer_contador #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             Load_C,
  output logic [WIDTH-1:0] data_out,
  output logic             Load_Reg,
  output logic             EmptyBuffer,
  output logic             FullBuffer,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             load_reg_q, load_reg_d;
  logic             overflow_q, overflow_d;

  logic consume;
  logic refill;
  logic write_ok;

  // Transfer decisions and next-state for pointers, count and output register
  always_comb begin
    consume    = enable & Load_C & load_reg_q;
    refill     = enable & (count_q != '0) & (~load_reg_q | consume);
    // A refill frees the head slot, so a full FIFO can still take a write
    write_ok   = enable & wr_en & ((count_q != FULL_CNT) | refill);

    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    load_reg_d = load_reg_q;
    overflow_d = overflow_q;

    if (refill) begin
      data_out_d = mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + AW'(1);
      load_reg_d = 1'b1;
    end else if (consume) begin
      load_reg_d = 1'b0;
    end

    if (write_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (enable & wr_en & ~write_ok) begin
      overflow_d = 1'b1;
    end

    case ({write_ok, refill})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      load_reg_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      load_reg_q <= load_reg_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents become unreachable on reset via the pointers
  always_ff @(posedge clk) begin
    if (write_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out    = data_out_q;
  assign Load_Reg    = load_reg_q;
  assign overflow    = overflow_q;
  assign EmptyBuffer = (count_q == '0);
  assign FullBuffer  = (count_q == FULL_CNT);

endmodule
